bus_mem_slave: RTL

BUS_MEM_SLAVE -- requirements
Module: bus_mem_slave

---
 rtl/bus_mem_pkg.sv | 10 +
 rtl/bus_mem_array.sv | 33 +++
 rtl/bus_mem_slave.sv | 103 ++++++++++
 3 files changed

// File: rtl/bus_mem_pkg.sv
// Shared types and helpers for the bus memory slave.
package bus_mem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    function automatic int num_lanes(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/bus_mem_array.sv
// Word storage with a synchronous byte-enabled write port and an asynchronous read port.
module bus_mem_array
    import bus_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                          clk,
    input  logic                          i_we,
    input  logic [IDX_W-1:0]              i_waddr,
    input  logic [DATA_W-1:0]             i_wdata,
    input  logic [num_lanes(DATA_W)-1:0]  i_be,
    input  logic [IDX_W-1:0]              i_raddr,
    output logic [DATA_W-1:0]             o_rdata
);

    localparam int NB = num_lanes(DATA_W);

    // No reset: contents are left as-is across reset.
    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < NB; b++) begin
                if (i_be[b]) r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/bus_mem_slave.sv
// Request/grant memory slave with programmable wait states and out-of-range error response.
module bus_mem_slave
    import bus_mem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req,
    input  logic                          wr_en,
    input  logic [ADDR_W-1:0]             addr,
    input  logic [DATA_W-1:0]             wdata,
    input  logic [num_lanes(DATA_W)-1:0]  be,
    output logic                          gnt,
    output logic [DATA_W-1:0]             rdata,
    output logic                          err
);

    localparam int                CNT_W    = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    state_t             r_state, w_next;
    logic [CNT_W-1:0]   r_cnt, w_cnt_next;
    logic               w_start;
    logic               w_oor;
    logic               w_we;
    logic [DATA_W-1:0]  w_mem_rdata;

    assign w_oor = ({1'b0, addr} >= DEPTH_L);
    assign w_we  = w_start & wr_en & ~w_oor;

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_start    = 1'b0;
        case (r_state)
            IDLE: begin
                if (req) begin
                    if (WAIT_STATES == 0) begin
                        w_next  = RESP;
                        w_start = 1'b1;
                    end else begin
                        w_next     = WAIT;
                        w_cnt_next = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                // Master dropping req mid-wait cancels the access outright.
                if (!req) begin
                    w_next     = IDLE;
                    w_cnt_next = '0;
                end else if (r_cnt == '0) begin
                    w_next  = RESP;
                    w_start = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            gnt     <= 1'b0;
            err     <= 1'b0;
            rdata   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            gnt     <= w_start;
            err     <= w_start & w_oor;
            if (w_start) begin
                if (w_oor)       rdata <= '0;
                else if (!wr_en) rdata <= w_mem_rdata;
            end
        end
    end

    bus_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (addr[IDX_W-1:0]),
        .i_wdata (wdata),
        .i_be    (be),
        .i_raddr (addr[IDX_W-1:0]),
        .o_rdata (w_mem_rdata)
    );

endmodule
